// File: rtl/crypt_ctrl.sv
// Block cipher DMA controller: fetches 64-bit blocks as two 32-bit words, runs
// them through an external cipher core and writes the result back.
module crypt_ctrl #(
  parameter int ADDR_W = 13
) (
  input  logic              AHB_HCLK,
  input  logic              AHB_HRESET,
  input  logic              ENABLE,
  input  logic [1:0]        CMDR,
  input  logic [ADDR_W-1:0] SAR_ADDR,
  input  logic [ADDR_W-1:0] DAR_ADDR,
  input  logic [ADDR_W-1:0] BSR,
  input  logic              INTR_CLR,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  input  logic [31:0]       MEM_RDATA,
  input  logic              MEM_ACK,
  output logic              CORE_START,
  output logic [1:0]        CORE_MODE,
  output logic [63:0]       CORE_DIN,
  input  logic [63:0]       CORE_DOUT,
  input  logic              CORE_DONE,
  output logic              BUSY,
  output logic              CRYPT_INTR,
  output logic [ADDR_W-1:0] DONE_CNT
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD0  = 3'd1;
  localparam logic [2:0] RD1  = 3'd2;
  localparam logic [2:0] RUN  = 3'd3;
  localparam logic [2:0] WR0  = 3'd4;
  localparam logic [2:0] WR1  = 3'd5;
  localparam logic [2:0] NEXT = 3'd6;
  localparam logic [2:0] FIN  = 3'd7;

  logic [2:0]        state_reg, state_next;
  logic              enable_d_reg;
  logic [1:0]        mode_reg;
  logic [ADDR_W-1:0] sar_reg, dar_reg, bsr_reg, blk_reg, done_cnt_reg;
  logic [63:0]       din_reg, dout_reg;
  logic              core_start_reg, intr_reg;

  logic              start_hit, abort, is_rd, is_wr;
  logic [ADDR_W-1:0] blk_off, word_off, done_inc;

  assign start_hit = (state_reg == IDLE) && ENABLE && !enable_d_reg &&
                     ((CMDR == 2'b01) || (CMDR == 2'b10));
  assign abort     = !ENABLE && (state_reg != IDLE) && (state_reg != FIN);
  assign is_rd     = (state_reg == RD0) || (state_reg == RD1);
  assign is_wr     = (state_reg == WR0) || (state_reg == WR1);
  assign done_inc  = done_cnt_reg + 1'b1;

  // Each block occupies two consecutive words; address sums wrap naturally.
  assign blk_off   = blk_reg << 1;
  assign word_off  = {{(ADDR_W-1){1'b0}}, (state_reg == RD1) || (state_reg == WR1)};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_hit) state_next = (BSR == '0) ? FIN : RD0;
      RD0:     if (MEM_ACK) state_next = RD1;
      RD1:     if (MEM_ACK) state_next = RUN;
      RUN:     if (CORE_DONE) state_next = WR0;
      WR0:     if (MEM_ACK) state_next = WR1;
      WR1:     if (MEM_ACK) state_next = NEXT;
      NEXT:    state_next = (done_inc < bsr_reg) ? RD0 : FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge AHB_HCLK or posedge AHB_HRESET) begin
    if (AHB_HRESET) begin
      state_reg      <= IDLE;
      enable_d_reg   <= 1'b0;
      mode_reg       <= 2'b00;
      sar_reg        <= '0;
      dar_reg        <= '0;
      bsr_reg        <= '0;
      blk_reg        <= '0;
      done_cnt_reg   <= '0;
      din_reg        <= '0;
      dout_reg       <= '0;
      core_start_reg <= 1'b0;
      intr_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      enable_d_reg   <= ENABLE;
      core_start_reg <= (state_reg == RD1) && MEM_ACK && !abort;

      // FIN wins over a coincident clear so a completion is never lost.
      if (start_hit) begin
        mode_reg     <= CMDR;
        sar_reg      <= SAR_ADDR;
        dar_reg      <= DAR_ADDR;
        bsr_reg      <= BSR;
        blk_reg      <= '0;
        done_cnt_reg <= '0;
        intr_reg     <= 1'b0;
      end else if (state_reg == FIN) begin
        intr_reg <= 1'b1;
      end else if (INTR_CLR) begin
        intr_reg <= 1'b0;
      end

      if (!abort) begin
        case (state_reg)
          RD0:     if (MEM_ACK) din_reg[63:32] <= MEM_RDATA;
          RD1:     if (MEM_ACK) din_reg[31:0] <= MEM_RDATA;
          RUN:     if (CORE_DONE) dout_reg <= CORE_DOUT;
          NEXT: begin
            blk_reg      <= blk_reg + 1'b1;
            done_cnt_reg <= done_inc;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    MEM_ADDR  = '0;
    MEM_WDATA = 32'h0;
    if (is_rd) MEM_ADDR = sar_reg + blk_off + word_off;
    if (is_wr) begin
      MEM_ADDR  = dar_reg + blk_off + word_off;
      MEM_WDATA = (state_reg == WR0) ? dout_reg[63:32] : dout_reg[31:0];
    end
  end

  assign MEM_REQ    = is_rd || is_wr;
  assign MEM_WE     = is_wr;
  assign CORE_START = core_start_reg;
  assign CORE_MODE  = mode_reg;
  assign CORE_DIN   = din_reg;
  assign BUSY       = (state_reg != IDLE) && (state_reg != FIN);
  assign CRYPT_INTR = intr_reg;
  assign DONE_CNT   = done_cnt_reg;

endmodule

// File: tb/tb_crypt_ctrl.sv
// Directed bench for crypt_ctrl with a latency-programmable memory and a
// fixed-function cipher core model.
module tb_crypt_ctrl;

  logic        AHB_HCLK, AHB_HRESET, ENABLE, INTR_CLR;
  logic [1:0]  CMDR;
  logic [12:0] SAR_ADDR, DAR_ADDR, BSR;
  logic        MEM_REQ, MEM_WE, MEM_ACK;
  logic [12:0] MEM_ADDR;
  logic [31:0] MEM_WDATA, MEM_RDATA;
  logic        CORE_START, CORE_DONE;
  logic [1:0]  CORE_MODE;
  logic [63:0] CORE_DIN, CORE_DOUT;
  logic        BUSY, CRYPT_INTR;
  logic [12:0] DONE_CNT;

  crypt_ctrl #(.ADDR_W(13)) dut (
    .AHB_HCLK(AHB_HCLK), .AHB_HRESET(AHB_HRESET), .ENABLE(ENABLE), .CMDR(CMDR),
    .SAR_ADDR(SAR_ADDR), .DAR_ADDR(DAR_ADDR), .BSR(BSR), .INTR_CLR(INTR_CLR),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .CORE_START(CORE_START),
    .CORE_MODE(CORE_MODE), .CORE_DIN(CORE_DIN), .CORE_DOUT(CORE_DOUT),
    .CORE_DONE(CORE_DONE), .BUSY(BUSY), .CRYPT_INTR(CRYPT_INTR), .DONE_CNT(DONE_CNT)
  );

  initial AHB_HCLK = 1'b0;
  always #5 AHB_HCLK = ~AHB_HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] word_of(input logic [12:0] a);
    return 32'h5A5A_0000 | {19'b0, a};
  endfunction

  function automatic logic [63:0] core_f(input logic [63:0] d, input logic [1:0] m);
    return (m == 2'b01) ? (d ^ 64'h0F1E_2D3C_4B5A_6978) : ~d;
  endfunction

  // Memory model: acks after ack_delay wait cycles, logs every completed word.
  int          ack_delay = 0;
  int          wait_cnt, n_xfer, n_req_cyc;
  logic        pend, stable, p_we;
  logic [12:0] p_addr;
  logic [31:0] p_wdata;
  logic [12:0] log_addr [64];
  logic        log_we [64];
  logic [31:0] log_wdata [64];
  int          log_len [64];
  logic        log_stable [64];

  always @(negedge AHB_HCLK) begin
    MEM_ACK   = 1'b0;
    MEM_RDATA = 32'hDEAD_BEEF;
    if (AHB_HRESET) begin
      wait_cnt = 0; n_xfer = 0; n_req_cyc = 0; pend = 1'b0; stable = 1'b1;
    end else if (MEM_REQ) begin
      n_req_cyc++;
      if (pend && (MEM_ADDR !== p_addr || MEM_WE !== p_we || MEM_WDATA !== p_wdata))
        stable = 1'b0;
      pend = 1'b1; p_addr = MEM_ADDR; p_we = MEM_WE; p_wdata = MEM_WDATA;
      if (wait_cnt >= ack_delay) begin
        MEM_ACK = 1'b1;
        if (!MEM_WE) MEM_RDATA = word_of(MEM_ADDR);
        if (n_xfer < 64) begin
          log_addr[n_xfer]   = MEM_ADDR;
          log_we[n_xfer]     = MEM_WE;
          log_wdata[n_xfer]  = MEM_WDATA;
          log_len[n_xfer]    = wait_cnt + 1;
          log_stable[n_xfer] = stable;
        end
        n_xfer++;
        wait_cnt = 0; pend = 1'b0; stable = 1'b1;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0; pend = 1'b0; stable = 1'b1;
    end
  end

  // Core model: CORE_DONE pulses core_lat cycles after each CORE_START.
  int          core_lat = 2;
  int          core_cnt, n_start;
  logic        dbl_start, prev_start;
  logic [63:0] core_din;
  logic [1:0]  core_mode;
  logic [1:0]  log_mode [64];

  always @(negedge AHB_HCLK) begin
    CORE_DONE = 1'b0;
    CORE_DOUT = 64'hBAD0_BAD0_BAD0_BAD0;
    if (AHB_HRESET) begin
      core_cnt = 0; n_start = 0; dbl_start = 1'b0; prev_start = 1'b0;
    end else begin
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          CORE_DONE = 1'b1;
          CORE_DOUT = core_f(core_din, core_mode);
        end
      end
      if (CORE_START) begin
        if (prev_start) dbl_start = 1'b1;
        if (n_start < 64) log_mode[n_start] = CORE_MODE;
        n_start++;
        core_din = CORE_DIN; core_mode = CORE_MODE; core_cnt = core_lat;
      end
      prev_start = CORE_START;
    end
  end

  typedef struct {
    logic [1:0]  cmdr;
    logic [12:0] sar, dar, bsr;
    int          delay;
    logic [12:0] exp_rd_first, exp_rd_last, exp_wr_last;
    int          exp_done;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge AHB_HCLK);
  endtask

  task automatic do_reset();
    ENABLE = 1'b0; INTR_CLR = 1'b0;
    AHB_HRESET = 1'b1;
    tick(2);
    AHB_HRESET = 1'b0;
    tick(1);
  endtask

  task automatic launch(input logic [1:0] c, input logic [12:0] s, input logic [12:0] d,
                        input logic [12:0] b, input int dly, input int lat);
    ack_delay = dly; core_lat = lat;
    CMDR = c; SAR_ADDR = s; DAR_ADDR = d; BSR = b;
    ENABLE = 1'b0;
    tick(1);
    ENABLE = 1'b1;
  endtask

  task automatic wait_intr(input int max_cyc);
    int c;
    c = 0;
    while (CRYPT_INTR !== 1'b1 && c < max_cyc) begin
      tick(1);
      c++;
    end
    chk("intr_timeout", 64'(c < max_cyc), 64'd1);
  endtask

  task automatic wait_busy(input logic val, input int max_cyc);
    int c;
    c = 0;
    while (BUSY !== val && c < max_cyc) begin
      tick(1);
      c++;
    end
    chk("busy_timeout", 64'(c < max_cyc), 64'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_mem"}, {MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA}, 64'd0);
    chk({tag, "_ctl"}, {CORE_START, CORE_MODE, BUSY, CRYPT_INTR, DONE_CNT}, 64'd0);
    chk({tag, "_din"}, CORE_DIN, 64'd0);
  endtask

  task automatic check_log(input vec_t v);
    int          b, ph;
    logic [12:0] ea;
    logic [63:0] din, dout;
    chk("n_xfer", 64'(n_xfer), 64'(4 * v.bsr));
    chk("n_start", 64'(n_start), 64'(v.bsr));
    chk("dbl_start", 64'(dbl_start), 64'd0);
    chk("done_cnt", 64'(DONE_CNT), 64'(v.exp_done));
    chk("intr", 64'(CRYPT_INTR), 64'd1);
    chk("busy_end", 64'(BUSY), 64'd0);
    chk("rd_first", 64'(log_addr[0]), 64'(v.exp_rd_first));
    chk("rd_last", 64'(log_addr[4 * (v.bsr - 1) + 1]), 64'(v.exp_rd_last));
    chk("wr_last", 64'(log_addr[4 * v.bsr - 1]), 64'(v.exp_wr_last));
    for (int s = 0; s < n_start && s < 64; s++)
      chk($sformatf("mode%0d", s), 64'(log_mode[s]), 64'(v.cmdr));
    for (int k = 0; k < n_xfer && k < 64; k++) begin
      b  = k / 4;
      ph = k % 4;
      ea = (ph < 2) ? v.sar + 13'(2 * b + ph) : v.dar + 13'(2 * b + ph - 2);
      chk($sformatf("x%0d_addr", k), 64'(log_addr[k]), 64'(ea));
      chk($sformatf("x%0d_we", k), 64'(log_we[k]), 64'(ph >= 2));
      chk($sformatf("x%0d_len", k), 64'(log_len[k]), 64'(v.delay + 1));
      chk($sformatf("x%0d_stable", k), 64'(log_stable[k]), 64'd1);
      if (ph >= 2) begin
        din  = {word_of(v.sar + 13'(2 * b)), word_of(v.sar + 13'(2 * b + 1))};
        dout = core_f(din, v.cmdr);
        chk($sformatf("x%0d_wdata", k), 64'(log_wdata[k]),
            64'((ph == 2) ? dout[63:32] : dout[31:0]));
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    do_reset();
    launch(v.cmdr, v.sar, v.dar, v.bsr, v.delay, 2);
    tick(1);
    // Register inputs change after start; the latched copy must be used.
    CMDR = 2'b11; SAR_ADDR = 13'h0AAA; DAR_ADDR = 13'h1555; BSR = 13'd7;
    wait_intr(3000);
    check_log(v);
    $display("vec cmdr=%b sar=%h dar=%h bsr=%0d delay=%0d done_cnt=%0d xfers=%0d",
             v.cmdr, v.sar, v.dar, v.bsr, v.delay, DONE_CNT, n_xfer);
  endtask

  initial begin
    int x0, n, c;
    vecs[0] = '{2'b01, 13'h0010, 13'h0100, 13'd2, 0, 13'h0010, 13'h0013, 13'h0103, 2};
    vecs[1] = '{2'b10, 13'h0020, 13'h0200, 13'd3, 3, 13'h0020, 13'h0025, 13'h0205, 3};
    vecs[2] = '{2'b01, 13'h1FFF, 13'h0300, 13'd1, 1, 13'h1FFF, 13'h0000, 13'h0301, 1};
    vecs[3] = '{2'b10, 13'h1FFE, 13'h1FFF, 13'd2, 0, 13'h1FFE, 13'h0001, 13'h0002, 2};

    AHB_HRESET = 1'b1; ENABLE = 1'b0; INTR_CLR = 1'b0; CMDR = 2'b00;
    SAR_ADDR = '0; DAR_ADDR = '0; BSR = '0;
    tick(2);
    chk_reset_outs("por");
    AHB_HRESET = 1'b0;
    tick(1);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Zero-length job: FIN only, interrupt two edges after the start edge.
    do_reset();
    launch(2'b10, 13'h0040, 13'h0080, 13'd0, 0, 2);
    tick(1);
    chk("bsr0_intr_early", 64'(CRYPT_INTR), 64'd0);
    chk("bsr0_busy", 64'(BUSY), 64'd0);
    tick(1);
    chk("bsr0_intr", 64'(CRYPT_INTR), 64'd1);
    chk("bsr0_req", 64'(n_req_cyc), 64'd0);
    $display("seq bsr0 intr=%b req_cycles=%0d", CRYPT_INTR, n_req_cyc);

    // No-op command ignores the enable edge.
    INTR_CLR = 1'b1; tick(1); INTR_CLR = 1'b0;
    chk("clr_intr", 64'(CRYPT_INTR), 64'd0);
    launch(2'b11, 13'h0040, 13'h0080, 13'd2, 0, 2);
    tick(10);
    chk("nop_busy", 64'(BUSY), 64'd0);
    chk("nop_req", 64'(n_req_cyc), 64'd0);
    chk("nop_start", 64'(n_start), 64'd0);
    $display("seq cmdr11 busy=%b req_cycles=%0d", BUSY, n_req_cyc);

    // INTR_CLR after completion clears the interrupt.
    do_reset();
    launch(2'b01, 13'h0040, 13'h0080, 13'd1, 0, 2);
    wait_intr(500);
    INTR_CLR = 1'b1; tick(1); INTR_CLR = 1'b0;
    chk("intr_clr_after", 64'(CRYPT_INTR), 64'd0);
    tick(1);
    chk("intr_clr_hold", 64'(CRYPT_INTR), 64'd0);
    $display("seq intr_clr_after intr=%b", CRYPT_INTR);

    // INTR_CLR in the FIN cycle loses to the completion.
    launch(2'b01, 13'h0050, 13'h0090, 13'd1, 0, 2);
    wait_busy(1'b1, 50);
    wait_busy(1'b0, 500);
    chk("fin_intr_pre", 64'(CRYPT_INTR), 64'd0);
    INTR_CLR = 1'b1; tick(1); INTR_CLR = 1'b0;
    chk("fin_clr_intr", 64'(CRYPT_INTR), 64'd1);
    $display("seq intr_clr_in_fin intr=%b", CRYPT_INTR);

    // Abort during RUN of block 1 of 3; the start also clears the old interrupt.
    x0 = n_xfer;
    launch(2'b01, 13'h0060, 13'h00A0, 13'd3, 0, 8);
    n = 0; c = 0;
    while (n < 2 && c < 500) begin
      tick(1);
      if (CORE_START) n++;
      c++;
    end
    chk("abort_reach", 64'(n), 64'd2);
    ENABLE = 1'b0;
    tick(1);
    chk("abort_busy", 64'(BUSY), 64'd0);
    chk("abort_req", 64'(MEM_REQ), 64'd0);
    chk("abort_done", 64'(DONE_CNT), 64'd1);
    chk("abort_intr", 64'(CRYPT_INTR), 64'd0);
    tick(12);
    chk("abort_done_hold", 64'(DONE_CNT), 64'd1);
    chk("abort_xfers", 64'(n_xfer - x0), 64'd6);
    $display("seq abort done_cnt=%0d busy=%b xfers=%0d", DONE_CNT, BUSY, n_xfer - x0);

    // Reset asserted during WR0 clears outputs immediately.
    do_reset();
    launch(2'b10, 13'h0070, 13'h00B0, 13'd1, 3, 2);
    c = 0;
    while (MEM_WE !== 1'b1 && c < 500) begin
      tick(1);
      c++;
    end
    chk("wr0_reach", 64'(MEM_WE), 64'd1);
    AHB_HRESET = 1'b1;
    #1;
    chk_reset_outs("wr0_rst");
    $display("seq reset_in_wr0 req=%b busy=%b din=%h", MEM_REQ, BUSY, CORE_DIN);
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
